// File: rtl/dlygen_pkg.sv
// Shared types and constants for the delay/pulse generator.
// Optional burst support is selected by defining DLYGEN_BURST_EN.
package dlygen_pkg;

  localparam int CW_DEF = 18;
  localparam int BW     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A programmed shot count of zero still fires once.
  function automatic logic [BW-1:0] burst_norm(input logic [BW-1:0] b);
    return (b == '0) ? BW'(1) : b;
  endfunction

endpackage

// File: rtl/delay_pulse_gen_if.sv
// Host/timebase-facing signal bundle of delay_pulse_gen; burst is present only with DLYGEN_BURST_EN.
// Handshake: there is no valid/ready; tick is a one-cycle strobe, trig is an async level, outputs are registered.
interface delay_pulse_gen_if
  import dlygen_pkg::*;
#(
  parameter int CW = CW_DEF
) ();

  logic          tick;
  logic          trig;
  logic          abort;
  logic [CW-1:0] delay;
  logic [CW-1:0] width;
`ifdef DLYGEN_BURST_EN
  logic [BW-1:0] burst;
`endif
  logic          pulse;
  logic          busy;
  logic          done;
  state_t        state;

  modport master (
    output tick, trig, abort, delay, width,
`ifdef DLYGEN_BURST_EN
    output burst,
`endif
    input  pulse, busy, done, state
  );

  modport slave (
    input  tick, trig, abort, delay, width,
`ifdef DLYGEN_BURST_EN
    input  burst,
`endif
    output pulse, busy, done, state
  );

endinterface

// File: rtl/trig_sync_edge.sv
// Synchroniser for the asynchronous trigger level followed by a registered rising-edge detector.
// Latency from d_i rise to edge_o is SYNC_STAGES+1 clocks; edge_o is one cycle wide.
module trig_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_o <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/delay_pulse_gen.sv
// Trigger-started delay/pulse stage counting prescaled ticks; delay and width are latched per shot.
// Define DLYGEN_BURST_EN to add a per-trigger shot count (bus.burst).
module delay_pulse_gen
  import dlygen_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  delay_pulse_gen_if.slave bus
);

  logic          trg_edge;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wid_q, wid_d;
  logic [CW-1:0] width_norm;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          gap;
`ifdef DLYGEN_BURST_EN
  logic [CW-1:0] dly_q, dly_d;
  logic [BW-1:0] burst_q, burst_d;
`endif

  trig_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_trig_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.trig),
    .edge_o(trg_edge)
  );

  assign width_norm = (bus.width == '0) ? CW'(1) : bus.width;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    gap     = 1'b0;
`ifdef DLYGEN_BURST_EN
    dly_d   = dly_q;
    burst_d = burst_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (trg_edge) begin
          wid_d = width_norm;
`ifdef DLYGEN_BURST_EN
          dly_d   = bus.delay;
          burst_d = burst_norm(bus.burst);
`endif
          if (bus.delay == '0) begin
            state_d = PULSE;
            cnt_d   = width_norm;
          end else begin
            state_d = DELAY;
            cnt_d   = bus.delay;
          end
        end
      end
      DELAY: begin
        if (bus.tick) begin
          if (cnt_q <= CW'(1)) begin
            state_d = PULSE;
            cnt_d   = wid_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      PULSE: begin
        if (bus.tick) begin
          if (cnt_q <= CW'(1)) begin
            state_d = DONE;
`ifdef DLYGEN_BURST_EN
            if (burst_q > BW'(1)) begin
              burst_d = burst_q - BW'(1);
              if (dly_q == '0) begin
                // Back-to-back shots still need one low clock between pulses.
                state_d = PULSE;
                cnt_d   = wid_q;
                gap     = 1'b1;
              end else begin
                state_d = DELAY;
                cnt_d   = dly_q;
              end
            end
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition, including a trigger seen this cycle.
    if (bus.abort) begin
      state_d = IDLE;
    end
  end

  assign pulse_d = (state_d == PULSE) && !gap;
  assign busy_d  = (state_d != IDLE);
  assign done_d  = (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wid_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DLYGEN_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q   <= '0;
      burst_q <= '0;
    end else begin
      dly_q   <= dly_d;
      burst_q <= burst_d;
    end
  end
`endif

  assign bus.pulse = pulse_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// Directed bench for delay_pulse_gen: output transitions are logged as (kind, cycle) events
// and checked against hand-computed expectations queued by the stimulus process.
module tb_delay_pulse_gen;
  import dlygen_pkg::*;

  localparam int CW = 18;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  logic [31:0] exp_q[$];

  delay_pulse_gen_if #(.CW(CW)) bus ();

  delay_pulse_gen #(
    .CW         (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Timebase strobe: high during every cycle whose number is a multiple of 10.
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.tick = ((cyc % 10) == 0);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] ev(input logic [2:0] k, input int c);
    logic [31:0] cc;
    cc = c;
    return {k, cc[28:0]};
  endfunction

  function automatic string kind_name(input logic [2:0] k);
    case (k)
      3'd0: return "pulse_rise";
      3'd1: return "pulse_fall";
      3'd2: return "done_rise";
      3'd3: return "done_fall";
      3'd4: return "busy_rise";
      3'd5: return "busy_fall";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_ev(input logic [2:0] k, input int c);
    exp_q.push_back(ev(k, c));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%b want=%b cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic check_state(input string name, input state_t want);
    tests++;
    if (bus.state !== want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, bus.state, want, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic log_event(input logic [2:0] k);
    logic [31:0] got;
    logic [31:0] want;
    got = ev(k, cyc);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s got_cyc=%0d want=none", kind_name(k), cyc);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL event got=%s@%0d want=%s@%0d", kind_name(got[31:29]), got[28:0],
                 kind_name(want[31:29]), want[28:0]);
      end
    end
  endtask

  initial begin
    logic p_prev, d_prev, b_prev;
    p_prev = 1'b0;
    d_prev = 1'b0;
    b_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pulse !== p_prev) log_event(bus.pulse ? 3'd0 : 3'd1);
      if (bus.done  !== d_prev) log_event(bus.done  ? 3'd2 : 3'd3);
      if (bus.busy  !== b_prev) log_event(bus.busy  ? 3'd4 : 3'd5);
      p_prev = bus.pulse;
      d_prev = bus.done;
      b_prev = bus.busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    bus.trig   = 1'b0;
    bus.abort  = 1'b0;
    bus.delay  = '0;
    bus.width  = '0;
`ifdef DLYGEN_BURST_EN
    bus.burst  = 8'd1;
`endif

    wait_cyc(3);
    check_bit("reset_pulse", bus.pulse, 1'b0);
    check_bit("reset_busy", bus.busy, 1'b0);
    check_bit("reset_done", bus.done, 1'b0);
    check_state("reset_state", IDLE);
    wait_cyc(5);
    rst_n = 1'b1;

    // delay=3 width=2; config rewritten mid-shot must not matter
    wait_cyc(100);
    bus.delay = 18'd3;
    bus.width = 18'd2;
    bus.trig  = 1'b1;
    expect_ev(3'd4, 104);
    expect_ev(3'd0, 131);
    expect_ev(3'd1, 151);
    expect_ev(3'd2, 151);
    expect_ev(3'd3, 152);
    expect_ev(3'd5, 152);
    wait_cyc(110);
    bus.trig  = 1'b0;
    bus.delay = 18'd7;
    bus.width = 18'd9;
    wait_cyc(153);
    check_state("shot1_idle", IDLE);

    // delay=0 width=0 -> one-tick pulse one clock after the trigger edge
    wait_cyc(200);
    bus.delay = 18'd0;
    bus.width = 18'd0;
    bus.trig  = 1'b1;
    expect_ev(3'd0, 204);
    expect_ev(3'd4, 204);
    expect_ev(3'd1, 211);
    expect_ev(3'd2, 211);
    expect_ev(3'd3, 212);
    expect_ev(3'd5, 212);
    wait_cyc(205);
    check_state("zero_delay_pulse", PULSE);
    wait_cyc(220);
    bus.trig = 1'b0;

    // retrigger during PULSE, then level held ~100 clocks
    wait_cyc(300);
    bus.delay = 18'd0;
    bus.width = 18'd3;
    bus.trig  = 1'b1;
    expect_ev(3'd0, 304);
    expect_ev(3'd4, 304);
    expect_ev(3'd1, 331);
    expect_ev(3'd2, 331);
    expect_ev(3'd3, 332);
    expect_ev(3'd5, 332);
    wait_cyc(310);
    bus.trig = 1'b0;
    wait_cyc(315);
    bus.trig = 1'b1;
    wait_cyc(415);
    bus.trig = 1'b0;

    // abort during PULSE
    wait_cyc(500);
    bus.delay = 18'd1;
    bus.width = 18'd5;
    bus.trig  = 1'b1;
    expect_ev(3'd4, 504);
    expect_ev(3'd0, 511);
    expect_ev(3'd1, 526);
    expect_ev(3'd5, 526);
    wait_cyc(505);
    bus.trig = 1'b0;
    wait_cyc(525);
    bus.abort = 1'b1;
    wait_cyc(526);
    bus.abort = 1'b0;
    check_state("abort_idle", IDLE);

    // normal shot after abort
    wait_cyc(600);
    bus.delay = 18'd0;
    bus.width = 18'd1;
    bus.trig  = 1'b1;
    expect_ev(3'd0, 604);
    expect_ev(3'd4, 604);
    expect_ev(3'd1, 611);
    expect_ev(3'd2, 611);
    expect_ev(3'd3, 612);
    expect_ev(3'd5, 612);
    wait_cyc(605);
    bus.trig = 1'b0;

    // abort coincides with the trigger edge in IDLE: nothing happens
    wait_cyc(700);
    bus.trig = 1'b1;
    wait_cyc(703);
    bus.abort = 1'b1;
    wait_cyc(704);
    bus.abort = 1'b0;
    wait_cyc(705);
    bus.trig = 1'b0;
    check_state("abort_trig_idle", IDLE);

    // async reset mid-DELAY
    wait_cyc(800);
    bus.delay = 18'd5;
    bus.width = 18'd1;
    bus.trig  = 1'b1;
    expect_ev(3'd4, 804);
    expect_ev(3'd5, 813);
    wait_cyc(805);
    bus.trig = 1'b0;
    wait_cyc(812);
    check_state("pre_reset_delay", DELAY);
    #1 rst_n = 1'b0;
    #1;
    check_bit("async_reset_busy", bus.busy, 1'b0);
    check_bit("async_reset_pulse", bus.pulse, 1'b0);
    check_state("async_reset_state", IDLE);
    wait_cyc(815);
    rst_n = 1'b1;

    // fresh trigger after reset
    wait_cyc(900);
    bus.delay = 18'd2;
    bus.width = 18'd2;
    bus.trig  = 1'b1;
    expect_ev(3'd4, 904);
    expect_ev(3'd0, 921);
    expect_ev(3'd1, 941);
    expect_ev(3'd2, 941);
    expect_ev(3'd3, 942);
    expect_ev(3'd5, 942);
    wait_cyc(905);
    bus.trig = 1'b0;

`ifdef DLYGEN_BURST_EN
    // burst=3 delay=2 width=1
    wait_cyc(1000);
    bus.burst = 8'd3;
    bus.delay = 18'd2;
    bus.width = 18'd1;
    bus.trig  = 1'b1;
    expect_ev(3'd4, 1004);
    expect_ev(3'd0, 1021);
    expect_ev(3'd1, 1031);
    expect_ev(3'd0, 1051);
    expect_ev(3'd1, 1061);
    expect_ev(3'd0, 1081);
    expect_ev(3'd1, 1091);
    expect_ev(3'd2, 1091);
    expect_ev(3'd3, 1092);
    expect_ev(3'd5, 1092);
    wait_cyc(1005);
    bus.trig = 1'b0;

    // burst=2 delay=0: one low clock between back-to-back pulses
    wait_cyc(1200);
    bus.burst = 8'd2;
    bus.delay = 18'd0;
    bus.width = 18'd1;
    bus.trig  = 1'b1;
    expect_ev(3'd0, 1204);
    expect_ev(3'd4, 1204);
    expect_ev(3'd1, 1211);
    expect_ev(3'd0, 1212);
    expect_ev(3'd1, 1221);
    expect_ev(3'd2, 1221);
    expect_ev(3'd3, 1222);
    expect_ev(3'd5, 1222);
    wait_cyc(1205);
    bus.trig  = 1'b0;
    bus.burst = 8'd1;
`endif

    wait_cyc(1300);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events got_pending=%0d want=0 next=%s@%0d", exp_q.size(),
               kind_name(exp_q[0][31:29]), exp_q[0][28:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
